// File: rtl/cpu_pkg.sv
// Shared execute-pipeline definitions: forward-select codes, hazard FSM
// states and the scoreboard entry layout.
package cpu_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // Register tags are stored zero-extended to this width; REG_W must not exceed it.
  localparam int unsigned SB_RD_W = 8;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic               valid;
    logic               wren;
    logic               is_load;
    logic [SB_RD_W-1:0] rd;
  } sb_entry_t;

  function automatic logic sb_hit(input sb_entry_t e, input logic [SB_RD_W-1:0] rs);
    return e.valid && e.wren && (e.rd != '0) && (e.rd == rs);
  endfunction

  function automatic logic [1:0] fwd_sel(input sb_entry_t ex, input sb_entry_t mem,
                                         input logic [SB_RD_W-1:0] rs);
    if (sb_hit(ex, rs) && !ex.is_load) return FWD_MEM;
    if (sb_hit(mem, rs))               return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-entry in-flight destination scoreboard (EX, MEM, WB) with the
// load-use and forwarding match logic against the decode sources.
module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_rs1,
  input  logic [REG_W-1:0] i_rs2,
  input  logic             i_uses_rs1,
  input  logic             i_uses_rs2,
  input  logic [REG_W-1:0] i_rd,
  input  logic             i_wren,
  input  logic             i_is_load,
  input  logic             i_bubble,
  output logic             o_load_use,
  output logic [1:0]       o_fwd_a_nxt,
  output logic [1:0]       o_fwd_b_nxt
);

  sb_entry_t          r_ex, r_mem, r_wb;
  sb_entry_t          w_ex_new;
  logic [SB_RD_W-1:0] w_rs1, w_rs2;
  logic               w_ld_hit1, w_ld_hit2;

  assign w_rs1 = SB_RD_W'(i_rs1);
  assign w_rs2 = SB_RD_W'(i_rs2);

  // Invalid entries are stored as all-zero so no stale tag survives a bubble.
  always_comb begin
    w_ex_new = '0;
    if (i_id_valid && !i_bubble) begin
      w_ex_new.valid   = 1'b1;
      w_ex_new.wren    = i_wren;
      w_ex_new.is_load = i_is_load;
      w_ex_new.rd      = SB_RD_W'(i_rd);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_ex  <= w_ex_new;
      r_mem <= r_ex;
      r_wb  <= r_mem;
    end
  end

  always_comb begin
    w_ld_hit1   = i_uses_rs1 && sb_hit(r_ex, w_rs1);
    w_ld_hit2   = i_uses_rs2 && sb_hit(r_ex, w_rs2);
    o_load_use  = i_id_valid && r_ex.is_load && (w_ld_hit1 || w_ld_hit2);
    o_fwd_a_nxt = fwd_sel(r_ex, r_mem, w_rs1);
    o_fwd_b_nxt = fwd_sel(r_ex, r_mem, w_rs2);
  end

  // The WB entry only retires the write; it must obey the zeroed-when-invalid rule.
  always_ff @(posedge clk) begin
    if (rst_n) assert (r_wb.valid || (r_wb == '0));
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: load-use stall, jump squash sequencing
// and registered ALU operand forwarding selects.
module ex_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned JUMP_PENALTY = 2,
  parameter int unsigned REG_W        = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] id_write_reg,
  input  logic             id_reg_wrenable,
  input  logic             id_mem_to_reg,
  input  logic             ex_taken,
  output logic             pc_stall,
  output logic             ifid_flush,
  output logic             ex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  hz_state_e  r_state, w_state_nxt;
  logic [1:0] r_cnt, w_cnt_nxt;
  logic [1:0] r_fwd_a, r_fwd_b;
  logic [1:0] w_fwd_a_nxt, w_fwd_b_nxt;
  logic       w_load_use, w_squash;

  hazard_scoreboard #(.REG_W(REG_W)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_id_valid (id_valid),
    .i_rs1      (id_rs1),
    .i_rs2      (id_rs2),
    .i_uses_rs1 (id_uses_rs1),
    .i_uses_rs2 (id_uses_rs2),
    .i_rd       (id_write_reg),
    .i_wren     (id_reg_wrenable),
    .i_is_load  (id_mem_to_reg),
    .i_bubble   (ex_bubble),
    .o_load_use (w_load_use),
    .o_fwd_a_nxt(w_fwd_a_nxt),
    .o_fwd_b_nxt(w_fwd_b_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_fwd_a <= FWD_RF;
      r_fwd_b <= FWD_RF;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_fwd_a <= ex_bubble ? FWD_RF : w_fwd_a_nxt;
      r_fwd_b <= ex_bubble ? FWD_RF : w_fwd_b_nxt;
    end
  end

  // The ex_taken cycle is the first squash cycle, so SQUASH itself lasts
  // JUMP_PENALTY-1 cycles and cnt reaches 0 on the edge that leaves it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_squash    = 1'b0;
    case (r_state)
      RUN: begin
        if (ex_taken) begin
          w_squash = 1'b1;
          if (JUMP_PENALTY > 1) begin
            w_state_nxt = SQUASH;
            w_cnt_nxt   = 2'(JUMP_PENALTY - 1);
          end
        end
      end
      SQUASH: begin
        w_squash = 1'b1;
        if (r_cnt <= 2'd1) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    ifid_flush = w_squash;
    ex_bubble  = w_squash || w_load_use;
    pc_stall   = w_load_use && !w_squash;
  end

  assign fwd_a = r_fwd_a;
  assign fwd_b = r_fwd_b;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: load-use, forwarding, jump squash and reset.
module tb_ex_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_uses_rs1, id_uses_rs2, id_reg_wrenable, id_mem_to_reg, ex_taken;
  logic [4:0] id_rs1, id_rs2, id_write_reg;
  logic       pc_stall, ifid_flush, ex_bubble;
  logic [1:0] fwd_a, fwd_b;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  ex_hazard_ctrl #(.JUMP_PENALTY(2), .REG_W(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .id_write_reg   (id_write_reg),
    .id_reg_wrenable(id_reg_wrenable),
    .id_mem_to_reg  (id_mem_to_reg),
    .ex_taken       (ex_taken),
    .pc_stall       (pc_stall),
    .ifid_flush     (ifid_flush),
    .ex_bubble      (ex_bubble),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b)
  );

  // Present one decode slot mid-cycle; outputs are then sampled 1ns later.
  task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic wr, input logic ld, input logic tk);
    @(negedge clk);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_write_reg = rd; id_reg_wrenable = wr; id_mem_to_reg = ld; ex_taken = tk;
    #1;
  endtask

  task automatic idle();
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    id_write_reg = '0; id_reg_wrenable = 1'b0; id_mem_to_reg = 1'b0; ex_taken = 1'b0;
    #1;
    n_total++; if (pc_stall !== 1'b0)   $display("FAIL rst_stall: got %b want 0", pc_stall);   else n_pass++;
    n_total++; if (ifid_flush !== 1'b0) $display("FAIL rst_flush: got %b want 0", ifid_flush); else n_pass++;
    n_total++; if (ex_bubble !== 1'b0)  $display("FAIL rst_bubble: got %b want 0", ex_bubble); else n_pass++;
    n_total++; if (fwd_a !== 2'd0)      $display("FAIL rst_fwd_a: got %0d want 0", fwd_a);     else n_pass++;
    n_total++; if (fwd_b !== 2'd0)      $display("FAIL rst_fwd_b: got %0d want 0", fwd_b);     else n_pass++;
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    idle(); idle(); idle();
    issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);   // lw r3
    n_total++; if (pc_stall !== 1'b0) $display("FAIL lu_pre_stall: got %b want 0", pc_stall); else n_pass++;
    issue(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);   // add r4,r3,r1
    n_total++; if (pc_stall !== 1'b1)   $display("FAIL lu_stall: got %b want 1", pc_stall);    else n_pass++;
    n_total++; if (ex_bubble !== 1'b1)  $display("FAIL lu_bubble: got %b want 1", ex_bubble);  else n_pass++;
    n_total++; if (ifid_flush !== 1'b0) $display("FAIL lu_flush: got %b want 0", ifid_flush);  else n_pass++;
    issue(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);   // add held in decode
    n_total++; if (pc_stall !== 1'b0)  $display("FAIL lu_release_stall: got %b want 0", pc_stall);   else n_pass++;
    n_total++; if (ex_bubble !== 1'b0) $display("FAIL lu_release_bubble: got %b want 0", ex_bubble); else n_pass++;
    n_total++; if (fwd_a !== 2'd0)     $display("FAIL lu_bubble_fwd_a: got %0d want 0", fwd_a);      else n_pass++;
    idle();
    n_total++; if (fwd_a !== 2'd2) $display("FAIL lu_fwd_a: got %0d want 2", fwd_a); else n_pass++;
    n_total++; if (fwd_b !== 2'd0) $display("FAIL lu_fwd_b: got %0d want 0", fwd_b); else n_pass++;
  endtask

  task automatic test_load_use_both();
    idle(); idle();
    issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);   // lw r9
    issue(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);  // add r10,r9,r9
    n_total++; if (pc_stall !== 1'b1) $display("FAIL both_stall: got %b want 1", pc_stall); else n_pass++;
    issue(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    n_total++; if (pc_stall !== 1'b0) $display("FAIL both_single_stall: got %b want 0", pc_stall); else n_pass++;
    idle();
    n_total++; if (fwd_a !== 2'd2) $display("FAIL both_fwd_a: got %0d want 2", fwd_a); else n_pass++;
    n_total++; if (fwd_b !== 2'd2) $display("FAIL both_fwd_b: got %0d want 2", fwd_b); else n_pass++;
    idle();
    issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0);  // lw r11
    issue(1'b1, 5'd11, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0); // r11 named but not read
    n_total++; if (pc_stall !== 1'b0) $display("FAIL unused_src_stall: got %b want 0", pc_stall); else n_pass++;
  endtask

  task automatic test_fwd_ex();
    idle(); idle();
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);   // add r5,r1,r2
    issue(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);   // sub r6,r5,r5
    n_total++; if (pc_stall !== 1'b0) $display("FAIL fex_stall: got %b want 0", pc_stall); else n_pass++;
    idle();
    n_total++; if (fwd_a !== 2'd1) $display("FAIL fex_fwd_a: got %0d want 1", fwd_a); else n_pass++;
    n_total++; if (fwd_b !== 2'd1) $display("FAIL fex_fwd_b: got %0d want 1", fwd_b); else n_pass++;
  endtask

  task automatic test_fwd_mem();
    idle(); idle();
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);   // add r5
    issue(1'b1, 5'd9, 5'd10, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);  // independent
    issue(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);   // or r7,r5,r0
    n_total++; if (pc_stall !== 1'b0) $display("FAIL fmem_stall: got %b want 0", pc_stall); else n_pass++;
    idle();
    n_total++; if (fwd_a !== 2'd2) $display("FAIL fmem_fwd_a: got %0d want 2", fwd_a); else n_pass++;
    n_total++; if (fwd_b !== 2'd0) $display("FAIL fmem_fwd_b: got %0d want 0", fwd_b); else n_pass++;
  endtask

  task automatic test_fwd_priority();
    idle(); idle();
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);   // add r5
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);   // add r5 again
    issue(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    idle();
    n_total++; if (fwd_a !== 2'd1) $display("FAIL prio_fwd_a: got %0d want 1", fwd_a); else n_pass++;
    n_total++; if (fwd_b !== 2'd1) $display("FAIL prio_fwd_b: got %0d want 1", fwd_b); else n_pass++;
  endtask

  task automatic test_jump();
    idle(); idle();
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);   // add r5
    issue(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1);   // reads r5, jump taken
    n_total++; if (ifid_flush !== 1'b1) $display("FAIL jmp_c1_flush: got %b want 1", ifid_flush); else n_pass++;
    n_total++; if (ex_bubble !== 1'b1)  $display("FAIL jmp_c1_bubble: got %b want 1", ex_bubble); else n_pass++;
    n_total++; if (pc_stall !== 1'b0)   $display("FAIL jmp_c1_stall: got %b want 0", pc_stall);   else n_pass++;
    idle();
    n_total++; if (ifid_flush !== 1'b1) $display("FAIL jmp_c2_flush: got %b want 1", ifid_flush); else n_pass++;
    n_total++; if (ex_bubble !== 1'b1)  $display("FAIL jmp_c2_bubble: got %b want 1", ex_bubble); else n_pass++;
    n_total++; if (pc_stall !== 1'b0)   $display("FAIL jmp_c2_stall: got %b want 0", pc_stall);   else n_pass++;
    n_total++; if (fwd_a !== 2'd0)      $display("FAIL jmp_bubble_fwd_a: got %0d want 0", fwd_a); else n_pass++;
    idle();
    n_total++; if (ifid_flush !== 1'b0) $display("FAIL jmp_c3_flush: got %b want 0", ifid_flush); else n_pass++;
    n_total++; if (ex_bubble !== 1'b0)  $display("FAIL jmp_c3_bubble: got %b want 0", ex_bubble); else n_pass++;
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);   // taken again while squashing
    n_total++; if (ifid_flush !== 1'b1) $display("FAIL jmp_resq_c2_flush: got %b want 1", ifid_flush); else n_pass++;
    idle();
    n_total++; if (ifid_flush !== 1'b0) $display("FAIL jmp_resq_c3_flush: got %b want 0", ifid_flush); else n_pass++;
  endtask

  task automatic test_jump_vs_load_use();
    idle(); idle();
    issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);   // lw r3
    issue(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1);   // use of r3 + jump taken
    n_total++; if (pc_stall !== 1'b0)   $display("FAIL jlu_stall: got %b want 0", pc_stall);    else n_pass++;
    n_total++; if (ifid_flush !== 1'b1) $display("FAIL jlu_flush: got %b want 1", ifid_flush);  else n_pass++;
    n_total++; if (ex_bubble !== 1'b1)  $display("FAIL jlu_bubble: got %b want 1", ex_bubble);  else n_pass++;
    idle(); idle();
  endtask

  task automatic test_reset_mid_squash();
    idle(); idle();
    issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    issue(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    idle();
    n_total++; if (fwd_a !== 2'd1) $display("FAIL arst_pre_fwd_a: got %0d want 1", fwd_a); else n_pass++;
    rst_n = 1'b0; #1;
    n_total++; if (fwd_a !== 2'd0) $display("FAIL arst_fwd_a: got %0d want 0", fwd_a); else n_pass++;
    n_total++; if (fwd_b !== 2'd0) $display("FAIL arst_fwd_b: got %0d want 0", fwd_b); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    idle();
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle();
    n_total++; if (ifid_flush !== 1'b1) $display("FAIL sq_rst_pre_flush: got %b want 1", ifid_flush); else n_pass++;
    rst_n = 1'b0; #1;
    n_total++; if (ifid_flush !== 1'b0) $display("FAIL sq_rst_flush: got %b want 0", ifid_flush); else n_pass++;
    n_total++; if (ex_bubble !== 1'b0)  $display("FAIL sq_rst_bubble: got %b want 0", ex_bubble); else n_pass++;
    n_total++; if (pc_stall !== 1'b0)   $display("FAIL sq_rst_stall: got %b want 0", pc_stall);   else n_pass++;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    idle();
    n_total++; if (ifid_flush !== 1'b0) $display("FAIL sq_post_rst_flush: got %b want 0", ifid_flush); else n_pass++;
    issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);   // lw r0
    issue(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);   // reads r0
    n_total++; if (pc_stall !== 1'b0)  $display("FAIL r0_stall: got %b want 0", pc_stall);   else n_pass++;
    n_total++; if (ex_bubble !== 1'b0) $display("FAIL r0_bubble: got %b want 0", ex_bubble); else n_pass++;
    idle();
    n_total++; if (fwd_a !== 2'd0) $display("FAIL r0_fwd_a: got %0d want 0", fwd_a); else n_pass++;
    n_total++; if (fwd_b !== 2'd0) $display("FAIL r0_fwd_b: got %0d want 0", fwd_b); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_load_use_both();
    test_fwd_ex();
    test_fwd_mem();
    test_fwd_priority();
    test_jump();
    test_jump_vs_load_use();
    test_reset_mid_squash();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
